// File: rtl/mod_exp_pkg.sv
// -----------------------------------------------------------------------------
// mod_exp_pkg
// Shared definitions for the sequential modular exponentiator:
//   - state_e    : exponentiator FSM states
//   - MODEXP_WIDTH : default operand width
//   - MM_CYCLES  : cycles from multiplier launch to its done flag
// -----------------------------------------------------------------------------
package mod_exp_pkg;

    localparam int MODEXP_WIDTH = 19;
    localparam int MM_CYCLES    = MODEXP_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SQR   = 3'd2,
        MUL   = 3'd3,
        FIN   = 3'd4
    } state_e;

endpackage

// File: rtl/mod_exp_seq_if.sv
// -----------------------------------------------------------------------------
// mod_exp_seq_if
// Request/response bundle of the modular exponentiator.
//   start  : request pulse (requester -> exponentiator)
//   base   : message / ciphertext, must be < n
//   exp    : exponent
//   n      : modulus
//   busy   : operation in progress
//   done   : one-cycle completion pulse
//   err    : illegal operands, valid with done
//   result : base^exp mod n
// Modports: master = requester side, slave = exponentiator side.
// -----------------------------------------------------------------------------
interface mod_exp_seq_if #(
    parameter int WIDTH = 19
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, base, exp, n,
        input  busy, done, err, result
    );

    modport slave (
        input  start, base, exp, n,
        output busy, done, err, result
    );
endinterface

// File: rtl/mod_mul_seq.sv
// -----------------------------------------------------------------------------
// mod_mul_seq
// Bit-serial interleaved modular multiplier: p = x*y mod n (x, y < n).
// One load cycle (go) followed by WIDTH iterations, MSB of y first.
//   clk, rst_n : clock, asynchronous active-low reset
//   go         : launch pulse, operands sampled on this cycle's edge
//   x, y, n    : multiplicand, multiplier, modulus
//   done       : high during the final iteration cycle
//   p          : product, valid while done is high
// done/p are presented during the final iteration so the caller can capture
// the product on the same edge the last iteration completes; this keeps the
// launch-to-capture distance at WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module mod_mul_seq #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Partial product is one bit wider so 2P and P+x never wrap at n = 2^WIDTH-1.
    logic [WIDTH:0]   p_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] n_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic [WIDTH:0]   dbl_s;
    logic [WIDTH:0]   red1_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   step_s;

    function automatic logic [WIDTH:0] cond_sub(input logic [WIDTH:0] v,
                                                input logic [WIDTH:0] m);
        if (v >= m) begin
            return v - m;
        end else begin
            return v;
        end
    endfunction

    // One interleaved iteration: double, reduce, conditionally add x, reduce.
    always_comb begin
        dbl_s  = p_r << 1'b1;
        red1_s = cond_sub(dbl_s, {1'b0, n_r});
        if (y_r[cnt_r]) begin
            sum_s = red1_s + {1'b0, x_r};
        end else begin
            sum_s = red1_s;
        end
        step_s = cond_sub(sum_s, {1'b0, n_r});
    end

    assign done = busy_r && (cnt_r == '0);
    assign p    = step_s[WIDTH-1:0];

    // Operand load on go, then one iteration per cycle down to bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r    <= '0;
            x_r    <= '0;
            y_r    <= '0;
            n_r    <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (go) begin
            p_r    <= '0;
            x_r    <= x;
            y_r    <= y;
            n_r    <= n;
            cnt_r  <= CNT_MSB;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            p_r <= step_s;
            if (cnt_r == '0) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end else begin
            p_r <= p_r;
        end
    end

endmodule

// File: rtl/mod_exp_seq.sv
// -----------------------------------------------------------------------------
// mod_exp_seq
// Sequential modular exponentiator, R = base^exp mod n, left-to-right binary
// square-and-multiply around one shared bit-serial modular multiplier.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any operation, no done)
//   bus   : mod_exp_seq_if.slave (start/base/exp/n in, busy/done/err/result out)
// Latency from the accepting edge to done: 2 + K*(WIDTH+1) cycles with
// K = WIDTH + popcount(exp); 2 cycles for illegal operands (n==0 or base>=n).
// Optional build macro MODEXP_CONST_TIME_EN: the multiply step runs for every
// exponent bit (product discarded when the bit is 0), so K = 2*WIDTH.
// -----------------------------------------------------------------------------
module mod_exp_seq
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = MODEXP_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    mod_exp_seq_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] acc_r;
    logic [IDX_W-1:0] idx_r;
    logic             err_pend_r;
    logic             mm_go_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [WIDTH-1:0] result_r;

    logic [WIDTH-1:0] mm_x_s;
    logic [WIDTH-1:0] mm_y_s;
    logic [WIDTH-1:0] mm_p_s;
    logic             mm_done_s;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.result = result_r;

    // Multiplier operands: acc*acc when squaring, acc*base when multiplying.
    always_comb begin
        mm_x_s = acc_r;
        case (state_r)
            MUL:     mm_y_s = base_r;
            default: mm_y_s = acc_r;
        endcase
    end

    mod_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mod_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (mm_go_r),
        .x     (mm_x_s),
        .y     (mm_y_s),
        .n     (n_r),
        .done  (mm_done_s),
        .p     (mm_p_s)
    );

    // Exponentiator FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            base_r     <= '0;
            exp_r      <= '0;
            n_r        <= '0;
            acc_r      <= '0;
            idx_r      <= '0;
            err_pend_r <= 1'b0;
            mm_go_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            result_r   <= '0;
        end else begin
            mm_go_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        base_r     <= bus.base;
                        exp_r      <= bus.exp;
                        n_r        <= bus.n;
                        busy_r     <= 1'b1;
                        err_r      <= 1'b0;
                        err_pend_r <= 1'b0;
                        state_r    <= CHECK;
                    end
                end
                CHECK: begin
                    if ((n_r == '0) || (base_r >= n_r)) begin
                        err_pend_r <= 1'b1;
                        state_r    <= FIN;
                    end else begin
                        // Anything mod 1 is 0, so seed the accumulator accordingly.
                        acc_r   <= (n_r == ONE_W) ? '0 : ONE_W;
                        idx_r   <= IDX_MSB;
                        mm_go_r <= 1'b1;
                        state_r <= SQR;
                    end
                end
                SQR: begin
                    if (mm_done_s) begin
                        acc_r <= mm_p_s;
`ifdef MODEXP_CONST_TIME_EN
                        mm_go_r <= 1'b1;
                        state_r <= MUL;
`else
                        if (exp_r[idx_r]) begin
                            mm_go_r <= 1'b1;
                            state_r <= MUL;
                        end else if (idx_r == '0) begin
                            state_r <= FIN;
                        end else begin
                            idx_r   <= idx_r - IDX_ONE;
                            mm_go_r <= 1'b1;
                        end
`endif
                    end
                end
                MUL: begin
                    if (mm_done_s) begin
`ifdef MODEXP_CONST_TIME_EN
                        // Dummy multiply on zero bits keeps timing independent of exp.
                        if (exp_r[idx_r]) begin
                            acc_r <= mm_p_s;
                        end
`else
                        acc_r <= mm_p_s;
`endif
                        if (idx_r == '0) begin
                            state_r <= FIN;
                        end else begin
                            idx_r   <= idx_r - IDX_ONE;
                            mm_go_r <= 1'b1;
                            state_r <= SQR;
                        end
                    end
                end
                FIN: begin
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    err_r    <= err_pend_r;
                    result_r <= err_pend_r ? '0 : acc_r;
                    state_r  <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
